// File: rtl/uart_stream_pkg.sv
package uart_stream_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HDR_R,
    ST_HDR_C,
    ST_HDR_B,
    ST_FETCH,
    ST_DATA,
    ST_CSUM,
    ST_GAP
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic int unsigned bytes_per_row(input int unsigned cols, input int unsigned bpc);
    return (cols * bpc) / 8;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
module uart_byte_tx #(
  parameter int unsigned BPS_NUM = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       uart_tx
);

  localparam int unsigned CNT_W = $clog2(BPS_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_NUM - 1);

  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  // The shift register refills with ones, so its LSB doubles as the idle-high line.
  always_comb begin
    shift_d  = shift_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (!active_q) begin
      if (byte_valid) begin
        shift_d  = {1'b1, byte_data, 1'b0};
        bit_d    = '0;
        cnt_d    = '0;
        active_d = 1'b1;
      end
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      shift_d = {1'b1, shift_q[9:1]};
      if (bit_q == 4'd9) begin
        active_d = 1'b0;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '1;
      bit_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign byte_ready = !active_q;
  assign uart_tx    = shift_q[0];

endmodule

// File: rtl/uart_frame_streamer.sv
module uart_frame_streamer
  import uart_stream_pkg::*;
#(
  parameter int unsigned AREA_ROW   = 32,
  parameter int unsigned AREA_COL   = 16,
  parameter int unsigned BPC        = 2,
  parameter int unsigned ROW_ADDR_W = 5,
  parameter int unsigned BPS_NUM    = 434,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int unsigned FRAME_GAP  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cont_mode,
  input  logic                      frame_req,
  output logic                      bitmap_rd,
  output logic [ROW_ADDR_W-1:0]     bitmap_row,
  input  logic [AREA_COL*BPC-1:0]   bitmap_data,
  output logic                      uart_tx,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int unsigned ROW_W    = AREA_COL * BPC;
  localparam int unsigned BPR      = bytes_per_row(AREA_COL, BPC);
  localparam int unsigned GAP_LAST = (FRAME_GAP == 0) ? 0 : FRAME_GAP - 1;
  localparam logic [7:0]  BYTE_LAST = 8'(BPR - 1);
  localparam logic [ROW_ADDR_W-1:0] ROW_LAST = ROW_ADDR_W'(AREA_ROW - 1);

  state_e                state_q, state_d;
  logic [ROW_ADDR_W-1:0] row_q, row_d;
  logic [7:0]            byte_idx_q, byte_idx_d;
  logic [ROW_W-1:0]      rowbuf_q, rowbuf_d;
  logic [7:0]            csum_q, csum_d;
  logic                  mode_q, mode_d;
  logic                  fetch_wait_q, fetch_wait_d;
  logic                  csum_sent_q, csum_sent_d;
  logic [31:0]           gap_cnt_q, gap_cnt_d;

  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] tx_byte;
  logic       csum_en;

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    byte_idx_d   = byte_idx_q;
    rowbuf_d     = rowbuf_q;
    csum_d       = csum_q;
    mode_d       = mode_q;
    fetch_wait_d = fetch_wait_q;
    csum_sent_d  = csum_sent_q;
    gap_cnt_d    = gap_cnt_q;
    bitmap_rd    = 1'b0;
    byte_valid   = 1'b0;
    tx_byte      = 8'h00;
    csum_en      = 1'b0;
    frame_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cont_mode || frame_req) begin
          mode_d  = cont_mode;
          csum_d  = '0;
          row_d   = '0;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        byte_valid = 1'b1;
        tx_byte    = SYNC_BYTE;
        if (byte_ready) state_d = ST_HDR_R;
      end
      ST_HDR_R: begin
        byte_valid = 1'b1;
        csum_en    = 1'b1;
        tx_byte    = 8'(AREA_ROW);
        if (byte_ready) state_d = ST_HDR_C;
      end
      ST_HDR_C: begin
        byte_valid = 1'b1;
        csum_en    = 1'b1;
        tx_byte    = 8'(AREA_COL);
        if (byte_ready) state_d = ST_HDR_B;
      end
      ST_HDR_B: begin
        byte_valid = 1'b1;
        csum_en    = 1'b1;
        tx_byte    = 8'(BPC);
        if (byte_ready) state_d = ST_FETCH;
      end
      // Two-cycle fetch: strobe, then capture on the following cycle.
      ST_FETCH: begin
        if (!fetch_wait_q) begin
          bitmap_rd    = 1'b1;
          fetch_wait_d = 1'b1;
        end else begin
          rowbuf_d     = bitmap_data;
          fetch_wait_d = 1'b0;
          byte_idx_d   = '0;
          state_d      = ST_DATA;
        end
      end
      ST_DATA: begin
        byte_valid = 1'b1;
        csum_en    = 1'b1;
        for (int unsigned k = 0; k < BPR; k++) begin
          if (byte_idx_q == 8'(k)) tx_byte = rowbuf_q[k*8 +: 8];
        end
        if (byte_ready) begin
          if (byte_idx_q == BYTE_LAST) begin
            if (row_q == ROW_LAST) begin
              state_d = ST_CSUM;
            end else begin
              row_d   = row_q + 1'b1;
              state_d = ST_FETCH;
            end
          end else begin
            byte_idx_d = byte_idx_q + 8'd1;
          end
        end
      end
      // Ready returning after the accepted checksum marks the end of its stop bit.
      ST_CSUM: begin
        if (!csum_sent_q) begin
          byte_valid = 1'b1;
          tx_byte    = csum_q;
          if (byte_ready) csum_sent_d = 1'b1;
        end else if (byte_ready) begin
          frame_done  = 1'b1;
          csum_sent_d = 1'b0;
          gap_cnt_d   = '0;
          state_d     = mode_q ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q >= 32'(GAP_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (csum_en && byte_valid && byte_ready) csum_d = csum_q ^ tx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      byte_idx_q   <= '0;
      rowbuf_q     <= '0;
      csum_q       <= '0;
      mode_q       <= 1'b0;
      fetch_wait_q <= 1'b0;
      csum_sent_q  <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      byte_idx_q   <= byte_idx_d;
      rowbuf_q     <= rowbuf_d;
      csum_q       <= csum_d;
      mode_q       <= mode_d;
      fetch_wait_q <= fetch_wait_d;
      csum_sent_q  <= csum_sent_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign bitmap_row = row_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_GAP);

  uart_byte_tx #(
    .BPS_NUM(BPS_NUM)
  ) u_byte_tx (
    .clk       (clk),
    .rst       (rst),
    .byte_data (tx_byte),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .uart_tx   (uart_tx)
  );

endmodule

// File: tb/tb_uart_frame_streamer.sv
module tb_uart_frame_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cont_a, req_a, rd_a, tx_a, busy_a, fd_a;
  logic [0:0]  row_a;
  logic [15:0] data_a;
  logic        cont_b, req_b, rd_b, tx_b, busy_b, fd_b;
  logic [0:0]  row_b;
  logic [7:0]  data_b;

  logic [15:0] mem_a [2];
  logic [7:0]  mem_b [1];
  logic [0:0]  last_a = 1'b0;

  uart_frame_streamer #(
    .AREA_ROW(2), .AREA_COL(8), .BPC(2), .ROW_ADDR_W(1),
    .BPS_NUM(4), .SYNC_BYTE(8'hA5), .FRAME_GAP(8)
  ) dut_a (
    .clk(clk), .rst(rst), .cont_mode(cont_a), .frame_req(req_a),
    .bitmap_rd(rd_a), .bitmap_row(row_a), .bitmap_data(data_a),
    .uart_tx(tx_a), .busy(busy_a), .frame_done(fd_a)
  );

  uart_frame_streamer #(
    .AREA_ROW(1), .AREA_COL(1), .BPC(8), .ROW_ADDR_W(1),
    .BPS_NUM(4), .SYNC_BYTE(8'hA5), .FRAME_GAP(8)
  ) dut_b (
    .clk(clk), .rst(rst), .cont_mode(cont_b), .frame_req(req_b),
    .bitmap_rd(rd_b), .bitmap_row(row_b), .bitmap_data(data_b),
    .uart_tx(tx_b), .busy(busy_b), .frame_done(fd_b)
  );

  // Synchronous memory: data registered on the read strobe, then keeps following the last-read row.
  always @(posedge clk) begin
    if (rd_a === 1'b1) begin
      last_a <= row_a;
      data_a <= mem_a[row_a];
    end else begin
      data_a <= mem_a[last_a];
    end
    data_b <= mem_b[0];
  end

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  logic [7:0]  exp_q [$];
  logic        sel = 1'b0;
  logic        mon_line;
  int unsigned bytes_seen = 0;
  int unsigned rd_cnt_a = 0, fd_cnt_a = 0, rd_cnt_b = 0, fd_cnt_b = 0;
  int unsigned rows_a [$];

  assign mon_line = sel ? tx_b : tx_a;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: decode 8N1 frames on the selected line and compare against the scoreboard.
  initial begin
    logic       s [40];
    logic [7:0] b;
    bit         aborted;
    bit         stable;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || mon_line !== 1'b0) continue;
      aborted = 1'b0;
      s[0] = mon_line;
      for (int i = 1; i < 40; i++) begin
        @(negedge clk);
        if (rst !== 1'b0) begin
          aborted = 1'b1;
          break;
        end
        s[i] = mon_line;
      end
      if (aborted) continue;
      stable = 1'b1;
      for (int j = 0; j < 10; j++)
        for (int k = 1; k < 4; k++)
          if (s[j*4+k] !== s[j*4]) stable = 1'b0;
      for (int j = 0; j < 8; j++) b[j] = s[4 + j*4];
      check("bit_timing", {31'b0, stable}, 32'd1);
      check("stop_bit", {31'b0, s[36]}, 32'd1);
      bytes_seen++;
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_byte: got %02h, expected none", b);
      end else begin
        check("byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rd_a === 1'b1) begin
        rd_cnt_a++;
        rows_a.push_back(row_a);
      end
      if (fd_a === 1'b1) fd_cnt_a++;
      if (rd_b === 1'b1) rd_cnt_b++;
      if (fd_b === 1'b1) fd_cnt_b++;
    end
  end

  logic [7:0] pkt_a [9];
  logic [7:0] pkt_b [6];

  task automatic push_a();
    for (int i = 0; i < 9; i++) exp_q.push_back(pkt_a[i]);
  endtask

  task automatic pulse_a();
    req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
  endtask

  task automatic wait_fd(input bit which, input int unsigned budget);
    int unsigned start;
    start = which ? fd_cnt_b : fd_cnt_a;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which ? fd_cnt_b : fd_cnt_a) > start) return;
    end
    vectors++;
    errors++;
    $display("FAIL frame_done_timeout: got no pulse, expected one within %0d cycles", budget);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base_rd, base_fd, idle, busy_low, seen0;
    bit found;
    pkt_a = '{8'hA5, 8'h02, 8'h08, 8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h48};
    pkt_b = '{8'hA5, 8'h01, 8'h01, 8'h08, 8'h5A, 8'h52};
    mem_a[0] = 16'h1234;
    mem_a[1] = 16'hABCD;
    mem_b[0] = 8'h5A;
    cont_a = 1'b0; req_a = 1'b0; cont_b = 1'b0; req_b = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx_a}, 32'd1);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_done", {31'b0, fd_a}, 32'd0);
    check("rst_rd", {31'b0, rd_a}, 32'd0);
    check("rst_row", {31'b0, row_a}, 32'd0);
    check("rst_tx_b", {29'b0, tx_b, busy_b, row_b}, 32'd4);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single on-demand frame
    base_rd = rd_cnt_a; base_fd = fd_cnt_a; rows_a.delete();
    push_a();
    pulse_a();
    wait_fd(1'b0, 3000);
    repeat (3) @(negedge clk);
    check("single_rd_pulses", rd_cnt_a - base_rd, 32'd2);
    check("single_rd_row0", (rows_a.size() > 0) ? rows_a[0] : 32'd99, 32'd0);
    check("single_rd_row1", (rows_a.size() > 1) ? rows_a[1] : 32'd99, 32'd1);
    check("single_done", fd_cnt_a - base_fd, 32'd1);
    check("single_busy_low", {31'b0, busy_a}, 32'd0);
    check("single_drained", exp_q.size(), 32'd0);
    repeat (60) @(negedge clk);
    check("single_no_repeat", fd_cnt_a - base_fd, 32'd1);

    // Requests while busy are dropped
    base_rd = rd_cnt_a; base_fd = fd_cnt_a;
    push_a();
    pulse_a();
    for (int n = 0; n < 200; n++) begin
      repeat (4) @(negedge clk);
      if (!busy_a) break;
      pulse_a();
    end
    repeat (60) @(negedge clk);
    check("busyreq_done", fd_cnt_a - base_fd, 32'd1);
    check("busyreq_rd", rd_cnt_a - base_rd, 32'd2);
    check("busyreq_drained", exp_q.size(), 32'd0);

    // Row buffer immune to memory change after capture
    base_fd = fd_cnt_a;
    push_a();
    pulse_a();
    found = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (rd_a === 1'b1 && row_a == 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("tear_rd_row1_seen", {31'b0, found}, 32'd1);
    @(negedge clk);
    mem_a[1] = 16'hFFFF;
    wait_fd(1'b0, 3000);
    repeat (3) @(negedge clk);
    check("tear_done", fd_cnt_a - base_fd, 32'd1);
    check("tear_drained", exp_q.size(), 32'd0);
    mem_a[1] = 16'hABCD;

    // Continuous mode: two packets with an idle gap
    base_fd = fd_cnt_a;
    push_a();
    push_a();
    cont_a = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (fd_a === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("cont_first_done", {31'b0, found}, 32'd1);
    idle = 0; busy_low = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (tx_a === 1'b0) break;
      idle++;
      if (busy_a === 1'b0) busy_low++;
    end
    check("cont_gap_idle_ge8", {31'b0, (idle >= 8)}, 32'd1);
    check("cont_gap_busy_low_ge8", {31'b0, (busy_low >= 8)}, 32'd1);
    check("cont_second_busy", {31'b0, busy_a}, 32'd1);
    cont_a = 1'b0;
    wait_fd(1'b0, 3000);
    repeat (60) @(negedge clk);
    check("cont_done_count", fd_cnt_a - base_fd, 32'd2);
    check("cont_drained", exp_q.size(), 32'd0);

    // Reset mid-packet, then a clean packet
    push_a();
    seen0 = bytes_seen;
    pulse_a();
    for (int n = 0; n < 3000; n++) begin
      if (bytes_seen >= seen0 + 4) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", {31'b0, tx_a}, 32'd1);
    check("midrst_busy", {31'b0, busy_a}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    base_fd = fd_cnt_a;
    push_a();
    pulse_a();
    wait_fd(1'b0, 3000);
    repeat (3) @(negedge clk);
    check("midrst_done", fd_cnt_a - base_fd, 32'd1);
    check("midrst_drained", exp_q.size(), 32'd0);

    // 1x1 geometry, 8 bits per cell
    sel = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) exp_q.push_back(pkt_b[i]);
    req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    wait_fd(1'b1, 3000);
    repeat (3) @(negedge clk);
    check("b_rd_pulses", rd_cnt_b, 32'd1);
    check("b_done", fd_cnt_b, 32'd1);
    check("b_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_streamer.md
Name: uart_frame_streamer

Overview:
- Parametrised successor of the bitmap-over-UART transmitter used for Tetris playfield debug/mirroring.
- Scans a row-addressed bitmap memory and serialises each frame as a framed packet: sync, header (rows, cols, bits-per-cell), packed payload, XOR checksum.
- Generalised in geometry and cell depth, with on-demand or continuous frame mode and a configurable inter-frame gap.
- Contains its own 8N1 serializer; drives the board UART TX pin directly.

Parameters:
- AREA_ROW, 32, bitmap rows (1..255).
- AREA_COL, 16, cells per row (1..255).
- BPC, 2, bits per cell (1, 2, 4 or 8); AREA_COL*BPC must be a multiple of 8.
- ROW_ADDR_W, 5, width of bitmap_row (>= clog2(AREA_ROW)).
- BPS_NUM, 434, clk cycles per UART bit (>= 2).
- SYNC_BYTE, 8'hA5, first byte of every packet.
- FRAME_GAP, 1024, idle clk cycles between packets in continuous mode (0 allowed).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cont_mode  in  1  1 = continuous frames; 0 = one frame per frame_req. Sampled only in IDLE.
- frame_req  in  1  single-cycle start request (on-demand mode).
- bitmap_rd  out  1  row read strobe.
- bitmap_row  out  ROW_ADDR_W  row address.
- bitmap_data  in  AREA_COL*BPC  row data, valid exactly 1 cycle after bitmap_rd. Cell c occupies bits [c*BPC +: BPC].
- uart_tx  out  1  serial line, idle high.
- busy  out  1  high from packet start until checksum stop bit ends (excludes GAP).
- frame_done  out  1  one-cycle pulse at end of the checksum stop bit.

Behaviour:
- Reset: uart_tx=1, busy=0, frame_done=0, bitmap_rd=0, bitmap_row=0, checksum=0, state IDLE. Reset mid-byte truncates the byte; the line goes high the cycle after rst is sampled.
- Packet byte order: SYNC_BYTE, AREA_ROW[7:0], AREA_COL[7:0], BPC[7:0], then payload. Payload is row 0 first; within a row, bytes run low to high (byte k = row bits [8k+7:8k]). Then the checksum byte.
- Checksum = XOR of the rows, cols, bpc and all payload bytes; SYNC_BYTE is excluded. Cleared at each packet start.
- States:
  - IDLE: if cont_mode or frame_req, go to SYNC and set busy.
  - SYNC: send SYNC_BYTE, then HDR_R.
  - HDR_R, HDR_C, HDR_B: send the header bytes in that order, then FETCH.
  - FETCH: assert bitmap_rd for 1 cycle with bitmap_row=r. On the next cycle, latch bitmap_data into the row buffer, then go to DATA.
  - DATA: send AREA_COL*BPC/8 bytes from the row buffer. After the last byte: if r < AREA_ROW-1, increment r and go to FETCH; otherwise go to CSUM.
  - CSUM: send the checksum, pulse frame_done, clear busy. Go to GAP if the mode latched at packet start is continuous, else IDLE.
  - GAP: count FRAME_GAP cycles, then IDLE (so cont_mode is re-sampled). FRAME_GAP=0 means IDLE on the next cycle.
- Row buffering: the row is latched once. Memory changes during DATA do not affect the bytes already buffered (no tearing within a row).
- Serializer:
  - Byte handshake: byte_valid/byte_ready. A byte is accepted only when both are high.
  - Frame: start bit 0, 8 data bits LSB first, 1 stop bit; each bit lasts exactly BPS_NUM cycles.
  - byte_ready returns high on the cycle after the stop bit completes.
  - Back-to-back bytes within a packet add no extra idle cycles beyond one handshake cycle.
- frame_req while busy or in GAP is ignored, not queued. frame_req coincident with rst is ignored.
- cont_mode changes mid-packet take effect only at the next IDLE.
- Row counter wraps to 0 at every packet start. bitmap_row never exceeds AREA_ROW-1.

Decomposition:
- Shared package uart_stream_pkg holds:
  - state encoding constants for the nine states;
  - the default SYNC_BYTE;
  - a function for bytes-per-row (AREA_COL*BPC/8).
- One sub-module, uart_byte_tx: 8N1 serializer with the byte_valid/byte_ready handshake. Parameter BPS_NUM; ports clk, rst, byte_data[7:0], byte_valid, byte_ready, uart_tx.
- Frame FSM, row buffer and checksum live in the top level.

Test Plan:
- Bench configuration: AREA_ROW=2, AREA_COL=8, BPC=2, BPS_NUM=4, FRAME_GAP=8. Memory: row0=16'h1234, row1=16'hABCD.
- cont_mode=0, single frame_req -> uart_tx decodes A5 02 08 02 34 12 CD AB 48; each bit lasts 4 clocks; exactly 2 bitmap_rd pulses (rows 0, 1); 1 frame_done pulse; busy then falls.
- cont_mode=1 held -> two identical consecutive packets; at least 8 idle-high cycles between the checksum stop bit and the next start bit; busy is low during the gap.
- frame_req pulses every 5 cycles while busy -> only one packet is emitted per accepted request; no back-to-back extra packet.
- Change row1 to 16'hFFFF one cycle after its bitmap_rd -> packet still carries CD AB and checksum 48.
- Assert rst during payload byte 5 -> uart_tx=1 and busy=0 on the next cycle; a later frame_req yields a complete correct packet starting with A5.
- BPC=8, AREA_COL=1, AREA_ROW=1, row0=8'h5A -> packet A5 01 01 08 5A 52.
